te_cmp: RTL and testbench

Clocked race-logic comparator for the temporal-coding datapath. Two `te` temporal encoders convert binary operands `a` and `b` into edge times relative to a toggling phase input `tin`. A pair of `cmp` edge-order comparators, one for rising edges and one for falling edges, determines which edge arrived later. The top multiplexes the comparator that matches the current phase and presents the result `tout = (a > b)`.

---
 rtl/te_pkg.sv | 12 +
 rtl/cmp.sv | 26 ++
 rtl/te.sv | 41 ++++
 rtl/te_cmp.sv | 65 ++++++
 tb/tb_te_cmp.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/te_pkg.sv
// Shared definitions for the temporal-coding comparator slice.
// DEF_BITS is the default operand width; SPAN is the number of cycles one
// phase can encode and PERIOD the minimum number of cycles tin is held.
package te_pkg;

  localparam int DEF_BITS = 2;
  localparam int SPAN     = 2 ** DEF_BITS;
  localparam int PERIOD   = SPAN + 1;

  typedef logic [DEF_BITS-1:0] te_cnt_t;

endpackage : te_pkg

// File: rtl/cmp.sv
// Registered edge-order latch. Records 1 only when y's edge is seen strictly
// before x's edge; a tie or x first leaves 0, and once both edges have
// arrived the decision is held.
module cmp (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  input  logic y,
  output logic out
);

  // Update the ordering decision from the current pair of edge levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      unique case ({x, y})
        2'b00:   out <= 1'b0;
        2'b01:   out <= 1'b1;
        2'b10:   out <= 1'b0;
        default: out <= out;
      endcase
    end
  end

endmodule : cmp

// File: rtl/te.sv
// Temporal encoder: converts an unsigned operand into an edge time.
// On every tin toggle the operand is captured into a down-counter; the
// output takes the new tin value once the counter has run out, so the
// output edge lands operand+1 cycles after the toggle is sampled.
module te
  import te_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tin,
  input  logic [BITS-1:0] d,
  output logic            q
);

  logic            tin_q;
  logic [BITS-1:0] cnt;

  // Toggle detection, operand capture and countdown towards the output edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order never changes behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tin_q <= 1'b0;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      tin_q <= tin;
      if (tin != tin_q) begin
        // New phase: the operand is only looked at on this cycle.
        cnt <= d;
      end else if (q != tin_q) begin
        // Encoding in progress: emit the edge once the count is spent.
        if (cnt == '0) q <= tin_q;
        else           cnt <= cnt - 1'b1;
      end
    end
  end

endmodule : te

// File: rtl/te_cmp.sv
// Race-logic comparator: tout = (a > b) once both encoded edges are in.
// Optional feature macro TE_CMP_DUAL_PHASE_EN: when defined, a second
// comparator watches the falling edges so every tin phase gives a result;
// otherwise only rising (tin=1) phases are meaningful.
module te_cmp
  import te_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tin,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            ta,
  output logic            tb,
  output logic            tout
);

  logic out_r;

  te #(.BITS(BITS)) u_te_a (
    .clk   (clk),
    .rst_n (rst_n),
    .tin   (tin),
    .d     (a),
    .q     (ta)
  );

  te #(.BITS(BITS)) u_te_b (
    .clk   (clk),
    .rst_n (rst_n),
    .tin   (tin),
    .d     (b),
    .q     (tb)
  );

  // Rising phase: ta/tb go 0->1, the later edge belongs to the larger value.
  cmp u_cmp_r (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (ta),
    .y     (tb),
    .out   (out_r)
  );

`ifdef TE_CMP_DUAL_PHASE_EN
  logic out_f;

  // Falling phase: invert so the encoded 1->0 edges look like rising edges.
  cmp u_cmp_f (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (~ta),
    .y     (~tb),
    .out   (out_f)
  );

  // Raw tin selects the comparator belonging to the current phase.
  assign tout = tin ? out_r : out_f;
`else
  assign tout = out_r;
`endif

endmodule : te_cmp

// File: tb/tb_te_cmp.sv
// Self-checking bench for te_cmp (BITS = 2). The reference model works in
// terms of edge times: after a toggle sampled at edge k, ta/tb show the new
// phase from edge k+1+operand, and tout is 1 from edge k+2+b when a > b.
module tb_te_cmp;
  import te_pkg::*;

  logic    clk;
  logic    rst_n;
  logic    tin;
  te_cnt_t a;
  te_cnt_t b;
  logic    ta;
  logic    tb;
  logic    tout;

  int total = 0;
  int bad   = 0;

  te_cmp #(.BITS(DEF_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tin   (tin),
    .a     (a),
    .b     (b),
    .ta    (ta),
    .tb    (tb),
    .tout  (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

`ifdef TE_CMP_DUAL_PHASE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  // One full phase. Called just after a clock edge; the toggle is sampled at
  // the next edge (k) and the next call toggles again after edge k+PERIOD-1.
  task automatic run_phase(input logic new_tin, input int oa, input int ob,
                           input bit scramble);
    logic exp_ta, exp_tb, exp_out;
    tin = new_tin;
    a   = te_cnt_t'(oa);
    b   = te_cnt_t'(ob);
    for (int n = 0; n < PERIOD; n++) begin
      @(posedge clk);
      #1;
      // Operand changes after the toggle cycle must not affect the result.
      if (scramble && n == 1) begin
        a = te_cnt_t'($urandom_range(SPAN - 1));
        b = te_cnt_t'($urandom_range(SPAN - 1));
      end
      exp_ta  = (n >= 1 + oa) ? new_tin : ~new_tin;
      exp_tb  = (n >= 1 + ob) ? new_tin : ~new_tin;
      exp_out = (oa > ob) && (n >= 2 + ob);
      check($sformatf("ta a=%0d n=%0d", oa, n), 32'(ta), 32'(exp_ta));
      check($sformatf("tb b=%0d n=%0d", ob, n), 32'(tb), 32'(exp_tb));
      if (DUAL || new_tin)
        check($sformatf("tout a=%0d b=%0d tin=%0b n=%0d", oa, ob, new_tin, n),
              32'(tout), 32'(exp_out));
    end
  endtask

  logic cur_tin;

  initial begin
    rst_n = 1'b0;
    tin   = 1'b0;
    a     = '0;
    b     = '0;
    cur_tin = 1'b0;

    // Reset state, then idle with tin=0: nothing may move.
    repeat (3) @(posedge clk);
    #1;
    check("reset ta", 32'(ta), 32'd0);
    check("reset tb", 32'(tb), 32'd0);
    check("reset tout", 32'(tout), 32'd0);
    rst_n = 1'b1;
    a = 2'd3;
    b = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("idle ta", 32'(ta), 32'd0);
      check("idle tb", 32'(tb), 32'd0);
      check("idle tout", 32'(tout), 32'd0);
    end

    // Exhaustive sweep twice; the extra phase between passes swaps the
    // tin polarity each operand pair sees.
    for (int rep = 0; rep < 2; rep++) begin
      for (int ia = 0; ia < SPAN; ia++) begin
        for (int ib = 0; ib < SPAN; ib++) begin
          cur_tin = ~cur_tin;
          run_phase(cur_tin, ia, ib, 1'b0);
        end
      end
      cur_tin = ~cur_tin;
      run_phase(cur_tin, 1, 1, 1'b0);
    end

    // Ties in both phases, ordering case a=1 b=3, and a=2 b=1 in both phases.
    for (int i = 0; i < 2; i++) begin
      cur_tin = ~cur_tin;
      run_phase(cur_tin, 2, 2, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      cur_tin = ~cur_tin;
      run_phase(cur_tin, 1, 3, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      cur_tin = ~cur_tin;
      run_phase(cur_tin, 2, 1, 1'b0);
    end

    // Random operands with mid-phase operand changes.
    for (int i = 0; i < 40; i++) begin
      cur_tin = ~cur_tin;
      run_phase(cur_tin, int'($urandom_range(SPAN - 1)),
                int'($urandom_range(SPAN - 1)), 1'b1);
    end

    // Reset in the middle of a rising phase with a=3, b=0.
    if (cur_tin) begin
      cur_tin = 1'b0;
      run_phase(cur_tin, 0, 0, 1'b0);
    end
    tin = 1'b1;
    a   = 2'd3;
    b   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset tb", 32'(tb), 32'd1);
    check("pre-reset ta", 32'(ta), 32'd0);
    check("pre-reset tout", 32'(tout), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset ta", 32'(ta), 32'd0);
    check("async reset tb", 32'(tb), 32'd0);
    check("async reset tout", 32'(tout), 32'd0);
    tin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset ta", 32'(ta), 32'd0);
    check("post-reset tout", 32'(tout), 32'd0);
    cur_tin = 1'b1;
    run_phase(cur_tin, 3, 0, 1'b0);
    cur_tin = 1'b0;
    run_phase(cur_tin, 3, 0, 1'b0);
    cur_tin = 1'b1;
    run_phase(cur_tin, 0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_te_cmp
